// File: rtl/ser2par_frm_if.sv
// Serial-in / parallel-out frame bus: serial input side plus word, status and error outputs.
interface ser2par_frm_if #(
   parameter int unsigned DW = 8
);
   logic          din;
   logic          wr_n;
   logic [DW-1:0] dout;
   logic          dout_vld;
   logic          busy;
   logic          frame_err;
   logic          par_err;

   modport master (
      output din, wr_n,
      input  dout, dout_vld, busy, frame_err, par_err
   );

   modport slave (
      input  din, wr_n,
      output dout, dout_vld, busy, frame_err, par_err
   );
endinterface

// File: rtl/ser2par_frm.sv
// Framed serial-to-parallel converter; wr_n low frames DW bits (plus an even-parity bit
// when SER2PAR_PARITY_EN is defined).
module ser2par_frm #(
   parameter int unsigned DW        = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input logic          clk,
   input logic          rst_n,
   ser2par_frm_if.slave bus
);
   localparam int unsigned CntW = $clog2(DW + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(DW - 1);

`ifdef SER2PAR_PARITY_EN
   typedef enum logic [1:0] {StIdle = 2'd0, StShift = 2'd1, StPar = 2'd2} state_e;
`else
   typedef enum logic [1:0] {StIdle = 2'd0, StShift = 2'd1} state_e;
`endif

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [DW-1:0]   sr_q, sr_d;
   logic [DW-1:0]   dout_q, dout_d;
   logic            vld_q, vld_d;
   logic            ferr_q, ferr_d;
   logic [DW-1:0]   shifted;
`ifdef SER2PAR_PARITY_EN
   logic            perr_q, perr_d;
`endif

   always_comb begin
      if (MSB_FIRST) shifted = {sr_q[DW-2:0], bus.din};
      else           shifted = {bus.din, sr_q[DW-1:1]};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      dout_d  = dout_q;
      vld_d   = 1'b0;
      ferr_d  = 1'b0;
`ifdef SER2PAR_PARITY_EN
      perr_d  = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
            if (!bus.wr_n) begin
               state_d = StShift;
               cnt_d   = CntW'(1);
               sr_d    = shifted;
            end
         end
         StShift: begin
            if (bus.wr_n) begin
               state_d = StIdle;
               cnt_d   = '0;
               sr_d    = '0;
               ferr_d  = 1'b1;
            end else if (cnt_q == LastCnt) begin
`ifdef SER2PAR_PARITY_EN
               state_d = StPar;
               cnt_d   = CntW'(DW);
               sr_d    = shifted;
`else
               state_d = StIdle;
               cnt_d   = '0;
               sr_d    = '0;
               dout_d  = shifted;
               vld_d   = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q + CntW'(1);
               sr_d  = shifted;
            end
         end
`ifdef SER2PAR_PARITY_EN
         StPar: begin
            state_d = StIdle;
            cnt_d   = '0;
            sr_d    = '0;
            if (bus.wr_n) begin
               ferr_d = 1'b1;
            end else if (bus.din == ^sr_q) begin
               dout_d = sr_q;
               vld_d  = 1'b1;
            end else begin
               perr_d = 1'b1;
            end
         end
`endif
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
            sr_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         sr_q    <= '0;
         dout_q  <= '0;
         vld_q   <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef SER2PAR_PARITY_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         dout_q  <= dout_d;
         vld_q   <= vld_d;
         ferr_q  <= ferr_d;
`ifdef SER2PAR_PARITY_EN
         perr_q  <= perr_d;
`endif
      end
   end

   assign bus.dout      = dout_q;
   assign bus.dout_vld  = vld_q;
   assign bus.frame_err = ferr_q;

   // A frame that just finished with wr_n still low is the start of a back-to-back frame.
`ifdef SER2PAR_PARITY_EN
   assign bus.par_err = perr_q;
   assign bus.busy    = (state_q != StIdle) || (!bus.wr_n && (vld_q || perr_q));
`else
   assign bus.par_err = 1'b0;
   assign bus.busy    = (state_q != StIdle) || (!bus.wr_n && vld_q);
`endif
endmodule

// File: tb/tb_ser2par_frm.sv
// Scoreboard bench for ser2par_frm: an MSB-first and an LSB-first instance share one serial
// stream; expected events are queued at stimulus time and popped by negedge monitors.
module tb_ser2par_frm;
   localparam int unsigned DW = 8;
`ifdef SER2PAR_PARITY_EN
   localparam int unsigned FL = DW + 1;
`else
   localparam int unsigned FL = DW;
`endif

   typedef struct {
      int         kind;  // 0 = word, 1 = frame_err, 2 = par_err
      logic [7:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   prev_vld = 0;
   int   last_vld = 0;
   exp_t q_m[$];
   exp_t q_l[$];
   logic [7:0] last_good [2];

   ser2par_frm_if #(.DW(DW)) ifm ();
   ser2par_frm_if #(.DW(DW)) ifl ();

   assign ifl.din  = ifm.din;
   assign ifl.wr_n = ifm.wr_n;

   ser2par_frm #(.DW(DW), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst_n(rst_n), .bus(ifm));
   ser2par_frm #(.DW(DW), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst_n(rst_n), .bus(ifl));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] rev(input logic [7:0] w);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = w[7-i];
      return r;
   endfunction

   task automatic push(input int kind, input logic [7:0] wm, input logic [7:0] wl);
      exp_t e;
      e.kind = kind;
      e.data = wm;
      q_m.push_back(e);
      e.data = wl;
      q_l.push_back(e);
   endtask

   task automatic mon(input int idx, input logic vld, input logic fe, input logic pe,
                      input logic [7:0] d);
      exp_t e;
      int   kind;
      bit   empty;
      if (!(vld || fe || pe)) return;
      check("single_pulse", 32'($countones({vld, fe, pe})), 32'd1);
      kind  = vld ? 0 : (fe ? 1 : 2);
      empty = 1'b0;
      if (idx == 0) begin
         if (q_m.size() == 0) empty = 1'b1;
         else e = q_m.pop_front();
      end else begin
         if (q_l.size() == 0) empty = 1'b1;
         else e = q_l.pop_front();
      end
      if (empty) begin
         n_cmp++;
         n_err++;
         $display("FAIL unexpected_pulse dut%0d: got event kind %0d, required none", idx, kind);
         return;
      end
      check("event_kind", 32'(kind), 32'(e.kind));
      if (e.kind == 0) begin
         check("dout_word", 32'(d), 32'(e.data));
         last_good[idx] = e.data;
      end else begin
         check("dout_hold", 32'(d), 32'(last_good[idx]));
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         mon(0, ifm.dout_vld, ifm.frame_err, ifm.par_err, ifm.dout);
         mon(1, ifl.dout_vld, ifl.frame_err, ifl.par_err, ifl.dout);
         if (ifm.dout_vld) begin
            prev_vld = last_vld;
            last_vld = cyc;
         end
      end
   end

   task automatic bit_out(input logic b);
      ifm.wr_n = 1'b0;
      ifm.din  = b;
      @(posedge clk);
      #1;
   endtask

   task automatic gap(input int n);
      ifm.wr_n = 1'b1;
      ifm.din  = 1'($urandom_range(0, 1));
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Full frame of word w sent first-bit-first from w[7]; flip corrupts the parity bit.
   task automatic send_frame(input logic [7:0] w, input bit flip);
      if (flip) push(2, 8'h00, 8'h00);
      else push(0, w, rev(w));
      for (int i = 0; i < 8; i++) begin
         bit_out(w[7-i]);
         check("busy_in_frame", 32'(ifm.busy), 32'd1);
      end
`ifdef SER2PAR_PARITY_EN
      bit_out((^w) ^ flip);
      check("busy_in_frame", 32'(ifm.busy), 32'd1);
`endif
   endtask

   task automatic abort_frame(input int k);
      push(1, 8'h00, 8'h00);
      for (int i = 0; i < k; i++) bit_out(1'($urandom_range(0, 1)));
      gap(1);
      check("busy_after_abort", 32'(ifm.busy), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int unsigned act;
      bit          flip;
      last_good[0] = 8'h00;
      last_good[1] = 8'h00;
      rst_n    = 1'b0;
      ifm.wr_n = 1'b1;
      ifm.din  = 1'b0;
      #12;
      check("rst_dout", 32'(ifm.dout), 32'd0);
      check("rst_vld", 32'(ifm.dout_vld), 32'd0);
      check("rst_busy", 32'(ifm.busy), 32'd0);
      check("rst_ferr", 32'(ifm.frame_err), 32'd0);
      check("rst_perr", 32'(ifm.par_err), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      gap(2);

      // 1,0,1,1,0,0,1,0
      send_frame(8'hB2, 1'b0);
      check("msb_first_B2", 32'(ifm.dout), 32'h0B2);
      check("lsb_first_4D", 32'(ifl.dout), 32'h04D);
      check("vld_pulse", 32'(ifm.dout_vld), 32'd1);
      gap(1);
      check("vld_one_cycle", 32'(ifm.dout_vld), 32'd0);
      check("busy_idle", 32'(ifm.busy), 32'd0);
      gap(2);

      send_frame(8'hA5, 1'b0);
      check("b2b_first", 32'(ifm.dout), 32'h0A5);
      send_frame(8'h3C, 1'b0);
      check("b2b_second", 32'(ifm.dout), 32'h03C);
      @(negedge clk);
      #1;
      check("vld_spacing", 32'(last_vld - prev_vld), 32'(FL));
      gap(2);

      abort_frame(5);
      check("abort_ferr", 32'(ifm.frame_err), 32'd1);
      check("abort_hold", 32'(ifm.dout), 32'h03C);
      gap(1);
      check("ferr_one_cycle", 32'(ifm.frame_err), 32'd0);

      for (int i = 0; i < 4; i++) bit_out(1'($urandom_range(0, 1)));
      rst_n = 1'b0;
      #1;
      check("async_rst_dout", 32'(ifm.dout), 32'd0);
      check("async_rst_busy", 32'(ifm.busy), 32'd0);
      check("async_rst_vld", 32'(ifm.dout_vld), 32'd0);
      check("async_rst_ferr", 32'(ifm.frame_err), 32'd0);
      last_good[0] = 8'h00;
      last_good[1] = 8'h00;
      ifm.wr_n = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send_frame(8'h81, 1'b0);
      check("post_rst_81", 32'(ifm.dout), 32'h081);
      gap(2);

`ifdef SER2PAR_PARITY_EN
      send_frame(8'h07, 1'b1);
      check("par_err_pulse", 32'(ifm.par_err), 32'd1);
      check("par_err_hold", 32'(ifm.dout), 32'h081);
      gap(1);
      send_frame(8'h07, 1'b0);
      check("par_ok_07", 32'(ifm.dout), 32'h007);
      check("par_ok_vld", 32'(ifm.dout_vld), 32'd1);
      gap(2);
`endif

      for (int n = 0; n < 60; n++) begin
         act = $urandom_range(0, 3);
`ifdef SER2PAR_PARITY_EN
         flip = ($urandom_range(0, 3) == 0);
`else
         flip = 1'b0;
`endif
         if (act == 0) abort_frame(int'($urandom_range(1, FL - 1)));
         else send_frame(8'($urandom), flip);
         gap(int'($urandom_range(0, 2)));
      end

      gap(3);
      check("queue_m_drained", 32'(q_m.size()), 32'd0);
      check("queue_l_drained", 32'(q_l.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/ser2par_frm.md
SER2PAR_FRM -- requirements
Module: ser2par_frm

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning parallel word width in bits, legal range 2..32.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, where 1 means the first serial bit lands in dout[DW-1] and 0 means it lands in dout[0].
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port din, input, 1 bit: serial data, sampled only while wr_n=0.
REQ-006 The block SHALL have port wr_n, input, 1 bit: active-low frame enable; it is held low for the whole frame.
REQ-007 The block SHALL have port dout, output, DW bits: last completed parallel word.
REQ-008 The block SHALL have port dout_vld, output, 1 bit: one-cycle pulse marking a new dout.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a frame is partially received.
REQ-010 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when a frame is aborted.
REQ-011 The block SHALL have port par_err, output, 1 bit: one-cycle pulse on a parity mismatch (see Configuration).

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and PAR (PAR exists only with the macro).
REQ-013 Transition IDLE->SHIFT: on a clk edge with wr_n=0; that edge samples bit 0 and sets bit count = 1.
REQ-014 In SHIFT, each edge with wr_n=0 SHALL sample din into the shift register per MSB_FIRST and increment the bit count.
REQ-015 On the edge that samples bit DW-1 (no parity), the word SHALL be written to dout and dout_vld asserted for the following cycle (latency 1 clk after the last bit).
REQ-016 Back-to-back frames: if wr_n stays low after a completed frame, the next edge SHALL sample bit 0 of a new frame with no idle gap.
REQ-017 Abort: wr_n=1 in SHIFT or PAR with count>0 SHALL discard the partial word, pulse frame_err for 1 cycle, return to IDLE, and leave dout unchanged.
REQ-018 busy SHALL be 1 in SHIFT/PAR and 0 in IDLE; it SHALL deassert in the same cycle dout_vld asserts, unless a back-to-back frame has begun.
REQ-019 dout SHALL hold its value between valid frames; dout_vld, frame_err and par_err SHALL never be high for 2 consecutive cycles from a single event.
REQ-020 The bit counter SHALL be $clog2(DW+1) bits wide, SHALL clear on frame completion or abort, and SHALL never wrap.

Reset
REQ-021 Asserting rst_n=0 SHALL immediately set state=IDLE, count=0, shift register=0, dout=0, dout_vld=0, busy=0, frame_err=0 and par_err=0.
REQ-022 Reset mid-frame SHALL discard the partial word with no frame_err pulse; after deassertion the first edge with wr_n=0 SHALL start a new frame.

Configuration
REQ-023 With macro SER2PAR_PARITY_EN defined, each frame SHALL carry DW data bits plus 1 even-parity bit; after the last data bit the FSM SHALL enter PAR and sample the parity bit.
REQ-024 With SER2PAR_PARITY_EN, on a parity match the block SHALL update dout and pulse dout_vld; on a mismatch it SHALL leave dout unchanged and pulse par_err instead, in both cases 1 clk after the parity bit.
REQ-025 Without SER2PAR_PARITY_EN, the PAR state and parity logic SHALL be absent, par_err SHALL be tied to 0, and a frame SHALL be DW bits.

Verification
REQ-026 Scenario: DW=8, MSB_FIRST=1, wr_n low for 8 cycles with serial 1,0,1,1,0,0,1,0 -> dout=8'hB2 and dout_vld high for 1 cycle after bit 8.
REQ-027 Scenario: same bits with MSB_FIRST=0 -> dout=8'h4D.
REQ-028 Scenario: wr_n low for 16 cycles carrying 8'hA5 then 8'h3C -> two dout_vld pulses 8 cycles apart, with dout=A5 then 3C, and busy never low between frames.
REQ-029 Scenario: wr_n rises after 5 bits -> frame_err pulses once, dout holds its prior value, busy falls.
REQ-030 Scenario: rst_n pulsed low after 4 bits -> all outputs 0 asynchronously; the next full frame 8'h81 is received correctly.
REQ-031 Scenario: SER2PAR_PARITY_EN, data 8'h07 with parity bit 1 -> dout=07 and dout_vld; with parity bit 0 -> par_err pulses and dout is unchanged.
